// File: rtl/c3lib_nand_filt_lcell_if.sv
// rtl/c3lib_nand_filt_lcell_if.sv - control/status bundle for the filtered NAND bank
// The master side drives enable and NAND inputs; the slave side returns filtered results.
interface c3lib_nand_filt_lcell_if #(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 2
);
    logic                    en;
    logic [NUM_IN*WIDTH-1:0] in_vec;
    logic [WIDTH-1:0]        out;
    logic [WIDTH-1:0]        out_chg;
    logic                    stable;

    modport master (
        output en,
        output in_vec,
        input  out,
        input  out_chg,
        input  stable
    );

    modport slave (
        input  en,
        input  in_vec,
        output out,
        output out_chg,
        output stable
    );
endinterface

// File: rtl/c3lib_nand_filt_lcell.sv
// rtl/c3lib_nand_filt_lcell.sv - WIDTH-bit bank of NUM_IN-input NANDs with per-bit deglitch filter
// Each out bit follows its NAND only after the new value has held for FILT_CYCLES clocks.
module c3lib_nand_filt_lcell #(
    parameter int   WIDTH       = 1,
    parameter int   NUM_IN      = 2,
    parameter int   FILT_CYCLES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    c3lib_nand_filt_lcell_if.slave bus
);

    localparam int CW = (FILT_CYCLES < 1) ? 1 : $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    if (NUM_IN < 2) begin : g_bad_num_in
        $error("c3lib_nand_filt_lcell: NUM_IN must be at least 2");
    end
    if (FILT_CYCLES < 1) begin : g_bad_filt
        $error("c3lib_nand_filt_lcell: FILT_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] and_acc;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] chg_q;
    logic             stable_q;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] chg_nxt;
    logic [WIDTH-1:0] pend_nxt;

    // Input i of every bit occupies one contiguous WIDTH-wide slice of in_vec.
    always_comb begin
        and_acc = '1;
        for (int i = 0; i < NUM_IN; i++) begin
            and_acc = and_acc & bus.in_vec[i*WIDTH +: WIDTH];
        end
    end

    assign raw = ~and_acc;

    always_comb begin
        out_nxt  = out_q;
        chg_nxt  = '0;
        pend_nxt = '0;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_nxt[b] = '0;
            // Disagreement only advances the count; the terminal count commits it.
            if (bus.en && (raw[b] != out_q[b])) begin
                if (cnt[b] >= CNT_LAST) begin
                    out_nxt[b] = raw[b];
                    chg_nxt[b] = 1'b1;
                end else begin
                    cnt_nxt[b] = cnt[b] + 1'b1;
                end
            end
            pend_nxt[b] = |cnt_nxt[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= {WIDTH{RST_VAL}};
            chg_q    <= '0;
            stable_q <= 1'b1;
            for (int b = 0; b < WIDTH; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            out_q    <= out_nxt;
            chg_q    <= chg_nxt;
            stable_q <= ~|pend_nxt;
            for (int b = 0; b < WIDTH; b++) begin
                cnt[b] <= cnt_nxt[b];
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.out_chg = chg_q;
    assign bus.stable  = stable_q;

endmodule

// File: doc/c3lib_nand_filt_lcell.md
Name: c3lib_nand_filt_lcell

Overview:
Parametrised successor to the 2-input NAND lcell. It is a WIDTH-bit bank of NUM_IN-input NAND gates. Each bit has a registered output qualified by a per-bit stability (deglitch) counter, so an output only changes after its NAND result has held the new value for FILT_CYCLES consecutive clocks. It is used on slow control and status paths, such as lane-enable and ready gating, where combinational glitches must not propagate.

Parameters:
WIDTH, 1, number of independent NAND bits (1..64)
NUM_IN, 2, inputs per NAND (2..8)
FILT_CYCLES, 2, consecutive cycles a new NAND value must hold before the output follows (1..255); 1 = plain registered NAND
RST_VAL, 1'b1, reset value of every out bit

Ports:
clk  input  1  block clock
rst_n  input  1  asynchronous active-low reset
en  input  1  filter enable; 0 = outputs frozen, counters cleared
in_vec  input  NUM_IN*WIDTH  NAND inputs; input i of bit b = in_vec[i*WIDTH+b]
out  output  WIDTH  filtered registered NAND result
out_chg  output  WIDTH  one-cycle pulse, per bit, in the cycle out[b] takes a new value
stable  output  1  1 when no bit has a pending change (all counters zero)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous assert, active-low. Deassertion is synchronised upstream.
- Reset values: out = {WIDTH{RST_VAL}}, out_chg = 0, stable = 1, all counters = 0.
- Combinational term: raw[b] = ~&(in_vec[i*WIDTH+b] for i = 0..NUM_IN-1). raw is internal only and never drives a port directly.
- Counter: each bit has cnt[b], width $clog2(FILT_CYCLES+1), saturating and never wrapping.
- Per-bit states: IDLE (cnt = 0) and PEND (cnt > 0).
- Per-bit update at each rising clk edge with en = 1:
  - raw[b] == out[b]: cnt -> 0, go to IDLE, out unchanged. A glitch that is shorter than the filter is dropped silently.
  - raw[b] != out[b] and cnt < FILT_CYCLES-1: cnt++, state PEND.
  - raw[b] != out[b] and cnt == FILT_CYCLES-1: out[b] <= raw[b], cnt -> 0, out_chg[b] = 1 for that cycle.
- Latency: out follows a steady raw change FILT_CYCLES edges after the first edge that samples the new value. With FILT_CYCLES = 1 this is a single flop stage: counter logic is present but degenerate, and out_chg still pulses.
- out_chg: registered. It is high exactly the cycle after the edge that updated out, aligned with the new out value, and low otherwise.
- stable: registered. stable = ~|cnt, evaluated on the registered counters.
- en = 0: all cnt cleared to 0, out held, out_chg = 0, stable = 1. On en rising, filtering restarts from cnt = 0, so a pending change needs a full FILT_CYCLES again.
- Simultaneous events: bits are fully independent. Any combination of bits may update in the same cycle, and out_chg may have several bits set.
- Reset mid-operation: pending counts are discarded and out returns to RST_VAL immediately (asynchronously). out_chg does not pulse because of reset.
- No X-propagation tolerance is required. Inputs are assumed known after reset deassertion and must be synchronous to clk.
- Elaboration checks: elaboration fails via a generate-time error if NUM_IN < 2 or FILT_CYCLES < 1.

Test Plan:
1. Reset and first update (WIDTH=4, NUM_IN=2, FILT_CYCLES=2, RST_VAL=1): drive in_vec = 8'hFF during reset, release rst_n.
   - out = 4'hF and stable = 1 during reset.
   - raw = 0, so out = 4'h0 and out_chg = 4'hF exactly on the 2nd edge after release (en = 1).
   - stable = 0 for 1 cycle, then returns to 1.
2. Glitch rejection (FILT_CYCLES=3): with out[0] = 1, drive both inputs of bit 0 high for 2 cycles, then drop one.
   - out[0] stays 1, out_chg = 0 throughout.
   - stable drops for 2 cycles, then returns to 1.
3. Exact threshold: hold the same stimulus as scenario 2 for exactly 3 cycles.
   - out[0] -> 0 on the 3rd edge, out_chg[0] pulses once.
   - Holding the stimulus longer produces no further out_chg pulses.
4. Enable freeze: start a change, then deassert en after 1 pending cycle and hold it low for 5 cycles with the stimulus held.
   - out holds, cnt clears, stable = 1 while en = 0.
   - After en returns to 1, out changes FILT_CYCLES edges later, not earlier.
5. Multi-bit and NUM_IN=3 (WIDTH=2, FILT_CYCLES=1): in_vec = 6'b111_111 -> out = 2'b00 and out_chg = 2'b11 after one edge; then clear input 1 of bit 1 only -> out = 2'b10 and out_chg = 2'b10 after one edge.
6. Async reset mid-pend: assert rst_n low between clock edges while cnt = 1.
   - out = RST_VAL immediately, without a clock edge.
   - After release, the pending change restarts from cnt = 0.
